rank_tracker: RTL and testbench
===============================

Name: rank_tracker

Overview:
- Sliding-window rank generator: the producer side of the rank-select path.
- Holds the last N input samples and maintains each sample's rank (0 = smallest) incrementally as samples enter and leave.
- Emits a packed sample bus and a packed rank bus, one sample slot per field, which a downstream rank selector consumes directly.
- Valid/ready stream in, valid/ready window out; one accepted sample per clock at full throughput.

Parameters:
- N, 3, window length in samples (N >= 2).
- DATA_BITS, 8, sample width, unsigned.
- RANK_BITS, 2, rank field width; must satisfy 2**RANK_BITS >= N.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous window flush; restarts the fill phase.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  DATA_BITS  new sample, unsigned.
- out_valid  out  1  s_out/r_out hold a full window not yet consumed.
- out_ready  in  1  consumer accepts the window.
- s_out  out  DATA_BITS*N  slot i at [DATA_BITS*i +: DATA_BITS]; slot 0 is newest, slot N-1 is oldest.
- r_out  out  RANK_BITS*N  rank of slot i at [RANK_BITS*i +: RANK_BITS].

Behaviour:
- Reset state (rst=1): all s slots 0; rank of slot i = N-1-i; fill_cnt 0; out_valid 0. in_ready is then 1.
- rst has priority over clear; clear has priority over an accept in the same cycle.
- clear produces the same state as rst.
- in_ready = !out_valid || out_ready (combinational).
- Accept = in_valid && in_ready. s_out/r_out change only on accept, so they are stable while out_valid=1 and out_ready=0.
- Total order (a precedes b) when value_a < value_b, or values are equal and a is older. Ranks in r_out are therefore always a permutation of 0..N-1.
- On accept, with x_old = slot N-1 and x_new = in_data:
  - Slots shift: slot i+1 <= slot i. Slot 0 <= x_new.
  - For each surviving sample j (old slots 0..N-2): rank_j' = rank_j - (x_old <= x_j) + (x_new < x_j).
  - New rank = number of surviving samples with value <= x_new.
  - Comparisons are unsigned at DATA_BITS. Intermediate rank arithmetic uses RANK_BITS+1 bits, and the result never leaves 0..N-1.
- fill_cnt saturates at N and increments on accept.
- out_valid next state:
  - Set to 1 on an accept where fill_cnt+1 >= N.
  - Else cleared to 0 when out_ready=1.
  - Else holds.
- Latency: the window reflecting a sample is on s_out/r_out the cycle after its accept.
- Fill phase (fill_cnt < N): the window updates normally, with the reset zeros acting as the oldest entries, but out_valid stays 0.
- Simultaneous out_ready and in_valid while out_valid=1: the old window is consumed and the new one loaded in the same edge; out_valid stays 1. This is full throughput.
- clear or rst mid-stream: any pending window is dropped with no handshake, and out_valid is 0 on the next cycle.

Decomposition:
- Shared package: sample and rank widths, the rank-field pack/unpack slicing, and a RANK_BITS = clog2(N) helper constant, so the tracker and the rank selector agree.
- One natural sub-module, rank_update_cell (instantiated N-1 times): inputs x_j, rank_j, x_old, x_new; outputs next rank_j and the (x_j <= x_new) bit used for the new sample's rank count.

Test Plan:
- Fill: N=3, push 5, 3, 9 with out_ready=1. out_valid=0 after 5 and after 3. After 9: s = {slot0 9, slot1 3, slot2 5}, r = {2, 0, 1}, out_valid=1.
- Slide: continue with push 1, which evicts 5. s = {1, 9, 3}, r = {0, 2, 1}. Then push 7, which evicts 3: s = {7, 1, 9}, r = {1, 0, 2}.
- Ties: after reset, push 4, 4, 4. Required r = {2, 1, 0}: the older equal sample ranks lower.
- Backpressure: with out_valid=1, hold out_ready=0 for 5 cycles while in_valid=1. Required: in_ready=0, s_out/r_out unchanged, no sample lost. Raise out_ready and the next window appears one cycle later.
- Clear/reset mid-fill: push 5, 3, assert clear, then push 8, 2, 6. out_valid first rises after 6 with s = {6, 2, 8} and r = {1, 0, 2}. Repeat the sequence using rst instead of clear.
- Random: 10k samples with random in_valid/out_ready against a sort-based model. On every accepted window, r_out matches the model and is a permutation of 0..N-1.

Source files
------------

// File: rtl/rank_tracker_pkg.sv
// Shared widths and bus-slicing helpers for the rank tracker and its downstream rank selector.
// Keeping them in one place makes both sides agree on field layout.
package rank_tracker_pkg;

  localparam int TRK_N         = 3;
  localparam int TRK_DATA_BITS = 8;
  localparam int TRK_RANK_BITS = (TRK_N > 1) ? $clog2(TRK_N) : 1;

  typedef logic [TRK_DATA_BITS-1:0] sample_t;
  typedef logic [TRK_RANK_BITS-1:0] rank_t;

  // Slot i of the packed buses; slot 0 is the newest sample.
  function automatic sample_t sample_field(input logic [TRK_DATA_BITS*TRK_N-1:0] bus, input int i);
    return bus[TRK_DATA_BITS*i +: TRK_DATA_BITS];
  endfunction

  function automatic rank_t rank_field(input logic [TRK_RANK_BITS*TRK_N-1:0] bus, input int i);
    return bus[TRK_RANK_BITS*i +: TRK_RANK_BITS];
  endfunction

endpackage

// File: rtl/rank_tracker_update_cell.sv
// Incremental rank update for one surviving sample when the oldest sample leaves
// and a new one enters; also reports whether this sample precedes the new one.
module rank_update_cell
  import rank_tracker_pkg::*;
#(
  parameter int DATA_BITS = TRK_DATA_BITS,
  parameter int RANK_BITS = TRK_RANK_BITS
) (
  input  logic [DATA_BITS-1:0] x_j,
  input  logic [RANK_BITS-1:0] rank_j,
  input  logic [DATA_BITS-1:0] x_old,
  input  logic [DATA_BITS-1:0] x_new,
  output logic [RANK_BITS-1:0] rank_next,
  output logic                 le_new
);

  logic [RANK_BITS:0] rank_wide;
  logic               unused_rank_msb;

  // The evicted sample is older, so it precedes x_j on ties; the new sample is
  // newer, so it only precedes x_j when strictly smaller.
  always_comb begin
    rank_wide = {1'b0, rank_j};
    if (x_old <= x_j) rank_wide = rank_wide - (RANK_BITS+1)'(1);
    if (x_new < x_j)  rank_wide = rank_wide + (RANK_BITS+1)'(1);
    rank_next       = rank_wide[RANK_BITS-1:0];
    unused_rank_msb = rank_wide[RANK_BITS];
    le_new          = (x_j <= x_new);
  end

endmodule

// File: rtl/rank_tracker.sv
// Sliding-window rank generator: keeps the last N samples and each sample's rank
// (0 = smallest, ties broken by age) and presents them as packed buses.
module rank_tracker
  import rank_tracker_pkg::*;
#(
  parameter int N         = TRK_N,
  parameter int DATA_BITS = TRK_DATA_BITS,
  parameter int RANK_BITS = TRK_RANK_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_BITS-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_BITS*N-1:0] s_out,
  output logic [RANK_BITS*N-1:0] r_out
);

  localparam int FILL_BITS = $clog2(N+1);

  logic [DATA_BITS-1:0] s_q [N];
  logic [RANK_BITS-1:0] r_q [N];
  logic [RANK_BITS-1:0] r_next [N-1];
  logic [N-2:0]         le_new;
  logic [RANK_BITS:0]   new_cnt;
  logic [RANK_BITS-1:0] new_rank;
  logic                 unused_cnt_msb;
  logic [FILL_BITS-1:0] fill_cnt;
  logic                 out_valid_q;
  logic                 accept;
  logic                 window_full;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Input is ready whenever no window is pending or the pending one is taken
  // this cycle, so a new window can replace a consumed one in the same edge.
  assign in_ready    = !out_valid_q || out_ready;
  assign accept      = in_valid && in_ready;
  assign window_full = (32'(fill_cnt) + 32'd1) >= 32'(N);
  assign out_valid   = out_valid_q;

  for (genvar j = 0; j < N-1; j++) begin : g_cell
    rank_update_cell #(
      .DATA_BITS (DATA_BITS),
      .RANK_BITS (RANK_BITS)
    ) u_cell (
      .x_j       (s_q[j]),
      .rank_j    (r_q[j]),
      .x_old     (s_q[N-1]),
      .x_new     (in_data),
      .rank_next (r_next[j]),
      .le_new    (le_new[j])
    );
  end

  always_comb begin
    new_cnt = '0;
    for (int j = 0; j < N-1; j++) begin
      new_cnt = new_cnt + (RANK_BITS+1)'(le_new[j]);
    end
    new_rank       = new_cnt[RANK_BITS-1:0];
    unused_cnt_msb = new_cnt[RANK_BITS];
  end

  // Reset zeros are a valid window: equal values, oldest slot ranked lowest.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < N; i++) begin
        s_q[i] <= '0;
        r_q[i] <= RANK_BITS'(N-1-i);
      end
      fill_cnt    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        s_q[0] <= in_data;
        r_q[0] <= new_rank;
        for (int i = 1; i < N; i++) begin
          s_q[i] <= s_q[i-1];
          r_q[i] <= r_next[i-1];
        end
        if (fill_cnt != FILL_BITS'(N)) fill_cnt <= fill_cnt + FILL_BITS'(1);
      end
      if (accept && window_full) out_valid_q <= 1'b1;
      else if (out_ready)        out_valid_q <= 1'b0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign s_out[DATA_BITS*i +: DATA_BITS] = s_q[i];
    assign r_out[RANK_BITS*i +: RANK_BITS] = r_q[i];
  end

endmodule

// File: tb/tb_rank_tracker.sv
// Directed and randomised checks of rank_tracker with N=3, DATA_BITS=8, RANK_BITS=2.
module tb_rank_tracker;
  import rank_tracker_pkg::*;

  localparam int W = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] s_out;
  logic [5:0]  r_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   m_s [3];
  int           m_fill;

  rank_tracker dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s_out     (s_out),
    .r_out     (r_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] sv(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
    return {a2, a1, a0};
  endfunction

  function automatic logic [5:0] rv(input logic [1:0] a0, input logic [1:0] a1, input logic [1:0] a2);
    return {a2, a1, a0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    #1 check("push_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Clear with a competing input sample: clear must win.
  task automatic do_clear();
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_s"}, 32'(s_out), 32'(sv(0, 0, 0)));
    check({tag, "_r"}, 32'(r_out), 32'(rv(2, 1, 0)));
    check({tag, "_vld"}, 32'(out_valid), 32'd0);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  task automatic flush_midfill(input bit use_rst);
    push(8'd5);
    push(8'd3);
    if (use_rst) do_reset();
    else do_clear();
    check_reset_state(use_rst ? "mid_rst" : "mid_clr");
    push(8'd8);
    check("mid_vld1", 32'(out_valid), 32'd0);
    push(8'd2);
    check("mid_vld2", 32'(out_valid), 32'd0);
    push(8'd6);
    check("mid_vld3", 32'(out_valid), 32'd1);
    check("mid_s", 32'(s_out), 32'(sv(6, 2, 8)));
    check("mid_r", 32'(r_out), 32'(rv(1, 0, 2)));
  endtask

  // Rank of slot i = number of samples that precede it; larger slot index is older.
  function automatic logic [W-1:0] model_window();
    logic [5:0]  r;
    logic [23:0] s;
    for (int i = 0; i < 3; i++) begin
      int cnt = 0;
      for (int k = 0; k < 3; k++) begin
        if (k != i && (m_s[k] < m_s[i] || (m_s[k] == m_s[i] && k > i))) cnt++;
      end
      r[2*i +: 2] = 2'(cnt);
      s[8*i +: 8] = m_s[i];
    end
    return {r, s};
  endfunction

  task automatic observe_cycle();
    logic [W-1:0] e;
    logic [2:0]   mask;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("rnd_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rnd_win", 32'({r_out, s_out}), 32'(e));
        mask = '0;
        for (int i = 0; i < 3; i++) mask[r_out[2*i +: 2]] = 1'b1;
        check("rnd_perm", 32'(mask), 32'h7);
      end
    end
    if (in_valid && in_ready) begin
      m_s[2] = m_s[1];
      m_s[1] = m_s[0];
      m_s[0] = in_data;
      if (m_fill < 3) m_fill++;
      if (m_fill == 3) exp_q.push_back(model_window());
    end
  endtask

  initial begin
    do_reset();
    check_reset_state("reset");

    // Fill and slide
    push(8'd5);
    check("fill_vld1", 32'(out_valid), 32'd0);
    push(8'd3);
    check("fill_vld2", 32'(out_valid), 32'd0);
    push(8'd9);
    check("fill_vld3", 32'(out_valid), 32'd1);
    check("fill_s", 32'(s_out), 32'(sv(9, 3, 5)));
    check("fill_r", 32'(r_out), 32'(rv(2, 0, 1)));
    push(8'd1);
    check("slide1_s", 32'(s_out), 32'(sv(1, 9, 3)));
    check("slide1_r", 32'(r_out), 32'(rv(0, 2, 1)));
    check("slide1_vld", 32'(out_valid), 32'd1);
    push(8'd7);
    check("slide2_s", 32'(s_out), 32'(sv(7, 1, 9)));
    check("slide2_r", 32'(r_out), 32'(rv(1, 0, 2)));

    // Backpressure: pending window holds, input stalls, sample 2 is kept
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd2;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_rdy", 32'(in_ready), 32'd0);
      check("bp_vld", 32'(out_valid), 32'd1);
      check("bp_s", 32'(s_out), 32'(sv(7, 1, 9)));
      check("bp_r", 32'(r_out), 32'(rv(1, 0, 2)));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_rel_s", 32'(s_out), 32'(sv(2, 7, 1)));
    check("bp_rel_r", 32'(r_out), 32'(rv(1, 2, 0)));
    check("bp_rel_vld", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("bp_drain_vld", 32'(out_valid), 32'd0);

    // Pending window dropped by clear
    push(8'd4);
    check("pend_vld", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    do_clear();
    check_reset_state("pend_clr");
    out_ready = 1'b1;

    // Ties: older equal sample ranks lower
    push(8'd4);
    push(8'd4);
    check("tie_vld2", 32'(out_valid), 32'd0);
    push(8'd4);
    check("tie_s", 32'(s_out), 32'(sv(4, 4, 4)));
    check("tie_r", 32'(r_out), 32'(rv(2, 1, 0)));
    check("tie_vld3", 32'(out_valid), 32'd1);

    do_reset();
    flush_midfill(1'b0);
    do_reset();
    flush_midfill(1'b1);

    // Random stream against the order model
    do_reset();
    for (int i = 0; i < 3; i++) m_s[i] = '0;
    m_fill = 0;
    exp_q.delete();
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      observe_cycle();
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      observe_cycle();
    end
    check("rnd_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
